// File: rtl/dn_port_arbiter_if.sv
// Bundle of requester, pause-handshake and core-port signals around dn_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dn_port_arbiter_if #(
  parameter int unsigned AW = 16
);
  logic          dl_active;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_wr;
  logic          nv_req;
  logic [AW-1:0] nv_addr;
  logic [7:0]    nv_data;
  logic          nv_wr;
  logic          nv_gnt;
  logic          nv_err;
  logic          cpu_paused;
  logic          pause_req;
  logic [AW-1:0] port_addr;
  logic [7:0]    port_data;
  logic          port_wr;
  logic [1:0]    port_sel;
  logic          busy;

  modport slave (
    input  dl_active, dl_addr, dl_data, dl_wr,
    input  nv_req, nv_addr, nv_data, nv_wr,
    input  cpu_paused,
    output nv_gnt, nv_err, pause_req,
    output port_addr, port_data, port_wr, port_sel, busy
  );

  modport master (
    output dl_active, dl_addr, dl_data, dl_wr,
    output nv_req, nv_addr, nv_data, nv_wr,
    output cpu_paused,
    input  nv_gnt, nv_err, pause_req,
    input  port_addr, port_data, port_wr, port_sel, busy
  );
endinterface

// File: rtl/dn_port_arbiter.sv
// Shares the core's download/NVRAM port between the ROM download stream and the
// hiscore NVRAM engine; NVRAM access is only granted while the CPU is paused.
module dn_port_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned PAUSEPAD = 2,
  parameter int unsigned TIMEOUT  = 4095
) (
  input logic              clk_sys,
  input logic              reset_n,
  dn_port_arbiter_if.slave bus
);

  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned PW = (PAUSEPAD > 0) ? $clog2(PAUSEPAD + 1) : 1;
  localparam logic [WW-1:0] WaitMax = WW'(TIMEOUT);
  localparam logic [PW-1:0] PadMax  = PW'(PAUSEPAD);

  typedef enum logic [2:0] {
    StIdle,
    StDl,
    StPauseReq,
    StPad,
    StNv,
    StRelease
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] pad_q, pad_d;
  logic          lock_q, lock_d;
  logic          err_d;
  logic          pause_d;
  logic          preempt;

  logic          nv_gnt_q, nv_err_q, pause_req_q, port_wr_q, busy_q;
  logic [1:0]    port_sel_q;
  logic [AW-1:0] port_addr_q;
  logic [7:0]    port_data_q;

  assign preempt = bus.dl_active && (state_q inside {StPauseReq, StPad, StNv, StRelease});

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pad_d   = pad_q;
    lock_d  = lock_q & bus.nv_req;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.dl_active) begin
          state_d = StDl;
        end else if (bus.nv_req && !lock_q) begin
          state_d = StPauseReq;
          wait_d  = '0;
        end
      end
      StDl: begin
        if (!bus.dl_active) state_d = StIdle;
      end
      StPauseReq: begin
        if (!bus.nv_req) begin
          state_d = StRelease;
          pad_d   = '0;
        end else if (bus.cpu_paused) begin
          state_d = StPad;
          pad_d   = '0;
        end else begin
          if (wait_q != WaitMax) wait_d = wait_q + 1'b1;
          if (wait_d == WaitMax) begin
            state_d = StIdle;
            err_d   = 1'b1;
            lock_d  = 1'b1;
          end
        end
      end
      StPad: begin
        // Wait counter keeps its value so repeated pause bounces still time out.
        if (!bus.nv_req) begin
          state_d = StRelease;
          pad_d   = '0;
        end else if (!bus.cpu_paused) begin
          state_d = StPauseReq;
        end else if (pad_q == PadMax) begin
          state_d = StNv;
        end else begin
          pad_d = pad_q + 1'b1;
        end
      end
      StNv: begin
        if (!bus.nv_req) begin
          state_d = StRelease;
          pad_d   = '0;
        end
      end
      StRelease: begin
        if (pad_q == PadMax) state_d = StIdle;
        else                 pad_d   = pad_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (preempt) begin
      state_d = StDl;
      err_d   = 1'b0;
      if (bus.nv_req) lock_d = 1'b1;
    end

    // Pause stays asserted for the first PAUSEPAD cycles of RELEASE.
    pause_d = (state_d inside {StPauseReq, StPad, StNv}) ||
              ((state_d == StRelease) && (pad_d != PadMax));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      pad_q       <= '0;
      lock_q      <= 1'b0;
      nv_gnt_q    <= 1'b0;
      nv_err_q    <= 1'b0;
      pause_req_q <= 1'b0;
      busy_q      <= 1'b0;
      port_sel_q  <= 2'b00;
      port_wr_q   <= 1'b0;
      port_addr_q <= '0;
      port_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pad_q       <= pad_d;
      lock_q      <= lock_d;
      nv_gnt_q    <= (state_d == StNv);
      nv_err_q    <= err_d;
      pause_req_q <= pause_d;
      busy_q      <= (state_d != StIdle);
      if (state_d == StDl) begin
        port_sel_q  <= 2'b01;
        port_wr_q   <= bus.dl_wr;
        port_addr_q <= bus.dl_addr;
        port_data_q <= bus.dl_data;
      end else if (state_d == StNv) begin
        port_sel_q  <= 2'b10;
        port_wr_q   <= bus.nv_wr;
        port_addr_q <= bus.nv_addr;
        port_data_q <= bus.nv_data;
      end else begin
        port_sel_q  <= 2'b00;
        port_wr_q   <= 1'b0;
      end
    end
  end

  assign bus.nv_gnt    = nv_gnt_q;
  assign bus.nv_err    = nv_err_q;
  assign bus.pause_req = pause_req_q;
  assign bus.busy      = busy_q;
  assign bus.port_sel  = port_sel_q;
  assign bus.port_wr   = port_wr_q;
  assign bus.port_addr = port_addr_q;
  assign bus.port_data = port_data_q;

endmodule

// File: tb/tb_dn_port_arbiter.sv
// Directed bench for dn_port_arbiter with PAUSEPAD=2 and TIMEOUT=16.
module tb_dn_port_arbiter;
  localparam int unsigned AW = 16;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  dn_port_arbiter_if #(.AW(AW)) bus ();

  dn_port_arbiter #(
    .AW      (AW),
    .PAUSEPAD(2),
    .TIMEOUT (16)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.nv_gnt),    32'd0);
    check({tag, "_err"},   32'(bus.nv_err),    32'd0);
    check({tag, "_pause"}, 32'(bus.pause_req), 32'd0);
    check({tag, "_sel"},   32'(bus.port_sel),  32'd0);
    check({tag, "_wr"},    32'(bus.port_wr),   32'd0);
    check({tag, "_addr"},  32'(bus.port_addr), 32'd0);
    check({tag, "_data"},  32'(bus.port_data), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),      32'd0);
  endtask

  initial begin
    bus.dl_active  = 1'b0;
    bus.dl_addr    = '0;
    bus.dl_data    = '0;
    bus.dl_wr      = 1'b0;
    bus.nv_req     = 1'b0;
    bus.nv_addr    = '0;
    bus.nv_data    = '0;
    bus.nv_wr      = 1'b0;
    bus.cpu_paused = 1'b0;

    step();
    step();
    check_all_zero("reset");
    reset_n = 1'b1;

    // Download stream; nv_req raised mid-download must be ignored.
    bus.dl_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dl_addr = 16'(i);
      bus.dl_data = 8'(8'h10 + i);
      bus.dl_wr   = 1'b1;
      if (i == 2) bus.nv_req = 1'b1;
      step();
      check("dl_sel",   32'(bus.port_sel),  32'd1);
      check("dl_wr",    32'(bus.port_wr),   32'd1);
      check("dl_addr",  32'(bus.port_addr), 32'(i));
      check("dl_data",  32'(bus.port_data), 32'(8'h10 + i));
      check("dl_pause", 32'(bus.pause_req), 32'd0);
      check("dl_gnt",   32'(bus.nv_gnt),    32'd0);
      bus.dl_wr = 1'b0;
      step();
      check("dl_wr_low", 32'(bus.port_wr), 32'd0);
    end

    bus.dl_active = 1'b0;
    step();
    check("dl_end_sel",  32'(bus.port_sel),  32'd0);
    check("dl_end_busy", 32'(bus.busy),      32'd0);
    check("hold_addr",   32'(bus.port_addr), 32'h3);
    check("hold_data",   32'(bus.port_data), 32'h13);

    // Pause handshake: cpu_paused arrives after 5 cycles of pause_req.
    step();
    check("preq_rise", 32'(bus.pause_req), 32'd1);
    check("preq_busy", 32'(bus.busy),      32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("preq_hold", 32'(bus.pause_req), 32'd1);
      check("preq_gnt",  32'(bus.nv_gnt),    32'd0);
    end
    bus.cpu_paused = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pad_gnt", 32'(bus.nv_gnt), 32'd0);
    end
    bus.nv_addr = 16'h03C0;
    bus.nv_data = 8'h5A;
    step();
    check("nv_gnt_rise", 32'(bus.nv_gnt),   32'd1);
    check("nv_sel",      32'(bus.port_sel), 32'd2);
    check("nv_wr_idle",  32'(bus.port_wr),  32'd0);
    bus.nv_wr = 1'b1;
    step();
    check("nv_wr",    32'(bus.port_wr),   32'd1);
    check("nv_addr",  32'(bus.port_addr), 32'h03C0);
    check("nv_data",  32'(bus.port_data), 32'h5A);
    check("nv_pause", 32'(bus.pause_req), 32'd1);
    bus.nv_wr = 1'b0;
    step();
    check("nv_wr_low", 32'(bus.port_wr), 32'd0);

    // Release sequence.
    bus.nv_req     = 1'b0;
    bus.cpu_paused = 1'b0;
    step();
    check("rel_gnt",   32'(bus.nv_gnt),    32'd0);
    check("rel_sel",   32'(bus.port_sel),  32'd0);
    check("rel_pause", 32'(bus.pause_req), 32'd1);
    step();
    check("rel_pause1", 32'(bus.pause_req), 32'd1);
    step();
    check("rel_pause2", 32'(bus.pause_req), 32'd0);
    check("rel_busy2",  32'(bus.busy),      32'd1);
    step();
    check("rel_idle", 32'(bus.busy), 32'd0);

    // Pause timeout with cpu_paused stuck low.
    bus.nv_req = 1'b1;
    step();
    check("to_preq", 32'(bus.pause_req), 32'd1);
    for (int i = 1; i < 16; i++) begin
      step();
      check("to_wait_pause", 32'(bus.pause_req), 32'd1);
      check("to_wait_err",   32'(bus.nv_err),    32'd0);
    end
    step();
    check("to_err",   32'(bus.nv_err),    32'd1);
    check("to_pause", 32'(bus.pause_req), 32'd0);
    check("to_busy",  32'(bus.busy),      32'd0);
    step();
    check("to_err_pulse", 32'(bus.nv_err),    32'd0);
    check("lock_pause",   32'(bus.pause_req), 32'd0);
    step();
    check("lock_pause2", 32'(bus.pause_req), 32'd0);
    bus.nv_req = 1'b0;
    step();
    check("unlock_pause", 32'(bus.pause_req), 32'd0);
    bus.nv_req = 1'b1;
    step();
    check("rearb_pause", 32'(bus.pause_req), 32'd1);

    // Download preempts an NVRAM write burst.
    bus.cpu_paused = 1'b1;
    for (int i = 0; i < 3; i++) step();
    step();
    check("pre_gnt", 32'(bus.nv_gnt), 32'd1);
    bus.nv_wr   = 1'b1;
    bus.nv_addr = 16'h0100;
    bus.nv_data = 8'hA0;
    step();
    check("burst_wr",   32'(bus.port_wr),   32'd1);
    check("burst_addr", 32'(bus.port_addr), 32'h0100);
    bus.nv_addr   = 16'h0101;
    bus.dl_active = 1'b1;
    bus.dl_addr   = 16'h2000;
    bus.dl_data   = 8'h77;
    step();
    check("pre_sel",   32'(bus.port_sel),  32'd1);
    check("pre_gnt0",  32'(bus.nv_gnt),    32'd0);
    check("pre_pause", 32'(bus.pause_req), 32'd0);
    check("pre_err",   32'(bus.nv_err),    32'd0);
    check("pre_wr",    32'(bus.port_wr),   32'd0);
    check("pre_addr",  32'(bus.port_addr), 32'h2000);
    step();
    check("pre_wr2",  32'(bus.port_wr),  32'd0);
    check("pre_sel2", 32'(bus.port_sel), 32'd1);
    bus.dl_active = 1'b0;
    bus.nv_wr     = 1'b0;
    step();
    check("pre_idle", 32'(bus.busy), 32'd0);
    step();
    check("pre_lock", 32'(bus.pause_req), 32'd0);
    bus.nv_req = 1'b0;
    step();
    bus.nv_req  = 1'b1;
    bus.nv_addr = 16'h1234;
    bus.nv_data = 8'h99;
    step();
    check("re_pause", 32'(bus.pause_req), 32'd1);
    for (int i = 0; i < 3; i++) step();
    step();
    check("re_gnt",  32'(bus.nv_gnt),    32'd1);
    check("re_addr", 32'(bus.port_addr), 32'h1234);

    // Asynchronous reset mid-cycle while in NV.
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
